// File: rtl/key_event_if.sv
// Event consumer port: valid/ready handshake carrying the head {code, type}.
// Master drives the event, slave returns ready.
interface key_event_if #(
    parameter int N = 16
);
    localparam int CW = $clog2(N);

    logic          ev_valid;
    logic          ev_ready;
    logic [CW-1:0] ev_code;
    logic [1:0]    ev_type;

    modport master (output ev_valid, ev_code, ev_type, input ev_ready);
    modport slave  (input ev_valid, ev_code, ev_type, output ev_ready);
endinterface

// File: rtl/key_event_queue.sv
// Button edges and auto-repeat ticks to a FWFT event queue.
// Latency: edge to ev_valid 2 cycles on an idle, empty queue.
// Backpressure: a full queue holds edges as per-button pending flags; merges set overflow.
module key_event_queue #(
    parameter int N             = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_WIDTH     = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn,
    input  logic [N-1:0] repeat_en,
    output logic         overflow,
    input  logic         ovf_clr,
    key_event_if.master  ev
);
    localparam int CW = $clog2(N);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] EV_PRESS = 2'b00;
    localparam logic [1:0] EV_REL   = 2'b01;
    localparam logic [1:0] EV_REP   = 2'b10;
    localparam logic [CNT_WIDTH-1:0] DELAY_LOAD  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LOAD = CNT_WIDTH'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_e;
    typedef struct packed {
        logic [CW-1:0] code;
        logic [1:0]    typ;
    } ev_t;

    logic [N-1:0]         btn_prev_q;
    logic [N-1:0]         pend_press_q, pend_press_d;
    logic [N-1:0]         pend_rel_q, pend_rel_d;
    logic                 pend_rep_q, pend_rep_d;
    logic                 ovf_q, ovf_d;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [CW-1:0]        tgt_q, tgt_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          cnt_q, cnt_d;
    ev_t                  mem [FIFO_DEPTH];

    logic [N-1:0]  rise, fall, rep_start, clr_press, clr_rel;
    logic          clr_rep, tick, cancel, merge;
    logic          valid, full, pop, room, push;
    logic          sel_found, start_found;
    logic [CW-1:0] sel_idx, start_idx;
    ev_t           push_ev, head;

    assign rise      = btn & ~btn_prev_q;
    assign fall      = ~btn & btn_prev_q;
    assign rep_start = rise & repeat_en;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = valid & ev.ev_ready;
    assign room  = ~full | pop;

    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        start_found = 1'b0;
        start_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_press_q[i] | pend_rel_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(i);
            end
            if (rep_start[i]) begin
                start_found = 1'b1;
                start_idx   = CW'(i);
            end
        end
    end

    // Lowest index wins, press before release; the repeat flag only gets leftover slots.
    always_comb begin
        push      = 1'b0;
        push_ev   = '0;
        clr_press = '0;
        clr_rel   = '0;
        clr_rep   = 1'b0;
        if (room) begin
            if (sel_found) begin
                push         = 1'b1;
                push_ev.code = sel_idx;
                if (pend_press_q[sel_idx]) begin
                    push_ev.typ        = EV_PRESS;
                    clr_press[sel_idx] = 1'b1;
                end else begin
                    push_ev.typ      = EV_REL;
                    clr_rel[sel_idx] = 1'b1;
                end
            end else if (pend_rep_q) begin
                push         = 1'b1;
                push_ev.code = tgt_q;
                push_ev.typ  = EV_REP;
                clr_rep      = 1'b1;
            end
        end
    end

    // An edge landing on a flag being drained in the same cycle is a fresh event, not a merge.
    assign pend_press_d = (pend_press_q & ~clr_press) | rise;
    assign pend_rel_d   = (pend_rel_q & ~clr_rel) | fall;
    assign merge        = (|(rise & pend_press_q & ~clr_press)) | (|(fall & pend_rel_q & ~clr_rel));
    assign ovf_d        = merge | (ovf_q & ~ovf_clr);
    assign pend_rep_d   = cancel ? 1'b0 : ((pend_rep_q & ~clr_rep) | tick);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tgt_d   = tgt_q;
        tick    = 1'b0;
        cancel  = 1'b0;
        if (start_found) begin
            state_d = ST_DELAY;
            timer_d = DELAY_LOAD;
            tgt_d   = start_idx;
            cancel  = 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (fall[tgt_q] | ~repeat_en[tgt_q]) begin
                state_d = ST_IDLE;
                cancel  = 1'b1;
            end else if (timer_q == '0) begin
                tick    = 1'b1;
                timer_d = PERIOD_LOAD;
                state_d = ST_REPEAT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q   <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
            pend_rep_q   <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            tgt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            btn_prev_q   <= btn;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            pend_rep_q   <= pend_rep_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_ev;
    end

    assign head        = mem[rd_ptr_q];
    assign ev.ev_valid = valid;
    assign ev.ev_code  = valid ? head.code : '0;
    assign ev.ev_type  = valid ? head.typ : '0;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (N=4, depth 4, delay 10, period 4).
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] repeat_en = '0;
    logic       ovf_clr = 1'b0;
    logic       overflow;
    int         checks = 0;
    int         errors = 0;

    int exp3_c[6] = '{0, 1, 2, 3, 0, 1};
    int exp3_t[6] = '{0, 0, 0, 0, 1, 1};
    int exp4_c[6] = '{0, 2, 3, 0, 1, 1};
    int exp4_t[6] = '{0, 1, 1, 1, 0, 1};

    key_event_if #(.N(4)) ev_if ();

    key_event_queue #(
        .N(4), .FIFO_DEPTH(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .repeat_en(repeat_en),
        .overflow(overflow), .ovf_clr(ovf_clr), .ev(ev_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input string tag, input int code, input int typ);
        check_eq({tag, ".valid"}, 32'(ev_if.ev_valid), 1);
        check_eq({tag, ".code"}, 32'(ev_if.ev_code), code);
        check_eq({tag, ".type"}, 32'(ev_if.ev_type), typ);
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        btn = 4'b0100;
        step(2);
        check_eq("rst.valid", 32'(ev_if.ev_valid), 0);
        check_eq("rst.code", 32'(ev_if.ev_code), 0);
        check_eq("rst.type", 32'(ev_if.ev_type), 0);
        check_eq("rst.ovf", 32'(overflow), 0);

        // Button held through reset shows up as a press two cycles after release.
        rst_n = 1'b1;
        step(1);
        check_eq("held.lat1", 32'(ev_if.ev_valid), 0);
        step(1);
        expect_ev("held", 2, 0);
        ev_if.ev_ready = 1'b1;
        step(1);
        check_eq("held.pop", 32'(ev_if.ev_valid), 0);
        step(3);
        check_eq("held.quiet", 32'(ev_if.ev_valid), 0);
        btn = 4'b0000;
        step(2);
        expect_ev("rel2", 2, 1);
        step(1);
        check_eq("rel2.empty", 32'(ev_if.ev_valid), 0);

        // Simultaneous rises drain in index order, one per cycle.
        btn = 4'b1011;
        step(1);
        check_eq("multi.lat1", 32'(ev_if.ev_valid), 0);
        step(1); expect_ev("multi.p0", 0, 0);
        step(1); expect_ev("multi.p1", 1, 0);
        step(1); expect_ev("multi.p3", 3, 0);
        step(1);
        check_eq("multi.empty", 32'(ev_if.ev_valid), 0);
        btn = 4'b0000;
        step(2); expect_ev("multi.r0", 0, 1);
        step(1); expect_ev("multi.r1", 1, 1);
        step(1); expect_ev("multi.r3", 3, 1);
        step(1);
        check_eq("multi.empty2", 32'(ev_if.ev_valid), 0);

        // Six events against a 4-deep queue: two wait as pending flags.
        ev_if.ev_ready = 1'b0;
        btn = 4'b1111;
        step(6);
        btn = 4'b1100;
        step(3);
        expect_ev("full.head", 0, 0);
        check_eq("full.ovf", 32'(overflow), 0);
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_ev($sformatf("full.e%0d", i), exp3_c[i], exp3_t[i]);
            step(1);
        end
        check_eq("full.empty", 32'(ev_if.ev_valid), 0);

        // Fill the queue, then merge a second rise of button 1 into its pending press.
        ev_if.ev_ready = 1'b0;
        btn = 4'b0001;
        step(5);
        btn = 4'b0000;
        step(3);
        btn = 4'b0010;
        step(1);
        check_eq("ovf.first", 32'(overflow), 0);
        btn = 4'b0000;
        step(1);
        check_eq("ovf.fall", 32'(overflow), 0);
        btn = 4'b0010;
        step(1);
        check_eq("ovf.merge", 32'(overflow), 1);
        step(1);
        check_eq("ovf.sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("ovf.clr", 32'(overflow), 0);
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_ev($sformatf("ovf.e%0d", i), exp4_c[i], exp4_t[i]);
            step(1);
        end
        check_eq("ovf.empty", 32'(ev_if.ev_valid), 0);
        btn = 4'b0000;
        step(2);
        expect_ev("ovf.r1", 1, 1);
        step(1);
        check_eq("ovf.empty2", 32'(ev_if.ev_valid), 0);

        // Auto-repeat: press at c=1, repeats at 11/15/19/23, release at 26.
        repeat_en = 4'b0001;
        step(2);
        btn = 4'b0001;
        for (int c = 0; c <= 30; c++) begin
            step(1);
            if (c == 1) begin
                expect_ev($sformatf("rep.c%0d", c), 0, 0);
            end else if (c == 11 || c == 15 || c == 19 || c == 23) begin
                expect_ev($sformatf("rep.c%0d", c), 0, 2);
            end else if (c == 26) begin
                expect_ev($sformatf("rep.c%0d", c), 0, 1);
            end else begin
                check_eq($sformatf("rep.idle%0d", c), 32'(ev_if.ev_valid), 0);
            end
            if (c == 24) btn = 4'b0000;
        end

        // Release during the initial delay: no repeat at all.
        step(2);
        btn = 4'b0001;
        for (int c = 0; c <= 20; c++) begin
            step(1);
            if (c == 1) begin
                expect_ev($sformatf("short.c%0d", c), 0, 0);
            end else if (c == 7) begin
                expect_ev($sformatf("short.c%0d", c), 0, 1);
            end else begin
                check_eq($sformatf("short.idle%0d", c), 32'(ev_if.ev_valid), 0);
            end
            if (c == 5) btn = 4'b0000;
        end

        // Asynchronous reset with three queued events.
        repeat_en = 4'b0000;
        ev_if.ev_ready = 1'b0;
        btn = 4'b0111;
        step(5);
        expect_ev("arst.queued", 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.valid", 32'(ev_if.ev_valid), 0);
        btn = 4'b0000;
        step(2);
        rst_n = 1'b1;
        ev_if.ev_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1);
            check_eq($sformatf("arst.stale%0d", c), 32'(ev_if.ev_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
